// File: rtl/bvashr_sge_witness_checker.sv
// bvashr_sge_witness_checker
// Sweeps every (s, t) pair of the bvsge/bvashr invertibility benchmark.
// For each pair it first brute-forces the invertibility condition
// ic = exists x : (x >>>a s) >=s t. It then asks an external Skolem
// responder for a witness x, and checks that the witness satisfies the
// claim whenever ic holds.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse; starts a sweep when idle
//   req_valid/req_ready   witness request handshake, carrying req_s/req_t
//   rsp_valid/rsp_x       one-cycle witness response
//   busy, done, pass      sweep status; pass is meaningful when done
//   fail_count            saturating count of failing vectors
//   timeout_seen          sticky flag for a response timeout
//   first_fail_s/t/x      vector and witness of the first failure
module bvashr_sge_witness_checker #(
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           req_valid,
  input  logic           req_ready,
  output logic [W-1:0]   req_s,
  output logic [W-1:0]   req_t,
  input  logic           rsp_valid,
  input  logic [W-1:0]   rsp_x,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   fail_count,
  output logic           timeout_seen,
  output logic [W-1:0]   first_fail_s,
  output logic [W-1:0]   first_fail_t,
  output logic [W-1:0]   first_fail_x
);

  localparam int FW = 2*W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [W:0]    W_VAL    = (W+1)'(W);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    REQ    = 3'd2,
    WAIT   = 3'd3,
    CHECK  = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Arithmetic right shift. Shift amounts of W or more saturate to the sign fill.
  function automatic logic [W-1:0] ashr_f(input logic [W-1:0] x, input logic [W-1:0] s);
    logic signed [W-1:0] xs;
    xs = x;
    if ({1'b0, s} >= W_VAL) begin
      return {W{x[W-1]}};
    end else begin
      return xs >>> s;
    end
  endfunction

  // Two's-complement signed a >= b.
  function automatic logic sge_f(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed(a) >= $signed(b);
  endfunction

  state_t          state_r;
  logic [W-1:0]    s_r;
  logic [W-1:0]    t_r;
  logic [W-1:0]    x_cnt_r;
  logic [W-1:0]    x_r;
  logic            ic_r;
  logic [TW-1:0]   tmo_r;

  logic            hit_s;
  logic            wit_ok_s;
  logic            last_vec_s;
  logic            fail_now_s;
  logic [W-1:0]    fail_x_s;

  assign req_s      = s_r;
  assign req_t      = t_r;
  assign hit_s      = sge_f(ashr_f(x_cnt_r, s_r), t_r);
  assign wit_ok_s   = sge_f(ashr_f(x_r, s_r), t_r);
  assign last_vec_s = (s_r == {W{1'b1}}) && (t_r == {W{1'b1}});

  // Failure detection: a witness that misses an invertible vector, or a response timeout.
  always_comb begin
    fail_now_s = 1'b0;
    fail_x_s   = {W{1'b0}};
    if (state_r == CHECK) begin
      fail_now_s = ic_r & ~wit_ok_s;
      fail_x_s   = x_r;
    end else if (state_r == WAIT) begin
      fail_now_s = ~rsp_valid & (tmo_r == TMO_LAST);
      fail_x_s   = {W{1'b0}};
    end else begin
      fail_now_s = 1'b0;
      fail_x_s   = {W{1'b0}};
    end
  end

  // Sweep controller, with registered status and failure bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      s_r          <= {W{1'b0}};
      t_r          <= {W{1'b0}};
      x_cnt_r      <= {W{1'b0}};
      x_r          <= {W{1'b0}};
      ic_r         <= 1'b0;
      tmo_r        <= {TW{1'b0}};
      req_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_count   <= {FW{1'b0}};
      timeout_seen <= 1'b0;
      first_fail_s <= {W{1'b0}};
      first_fail_t <= {W{1'b0}};
      first_fail_x <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            fail_count   <= {FW{1'b0}};
            timeout_seen <= 1'b0;
            first_fail_s <= {W{1'b0}};
            first_fail_t <= {W{1'b0}};
            first_fail_x <= {W{1'b0}};
            s_r          <= {W{1'b0}};
            t_r          <= {W{1'b0}};
            x_cnt_r      <= {W{1'b0}};
            ic_r         <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            state_r      <= SEARCH;
          end
        end
        SEARCH: begin
          ic_r    <= ic_r | hit_s;
          x_cnt_r <= x_cnt_r + {{(W-1){1'b0}}, 1'b1};
          if (x_cnt_r == {W{1'b1}}) begin
            req_valid <= 1'b1;
            state_r   <= REQ;
          end
        end
        REQ: begin
          // req_valid is always high here, so req_ready alone completes the handshake.
          if (req_ready) begin
            req_valid <= 1'b0;
            tmo_r     <= {TW{1'b0}};
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            x_r     <= rsp_x;
            state_r <= CHECK;
          end else if (tmo_r == TMO_LAST) begin
            timeout_seen <= 1'b1;
            state_r      <= NEXT;
          end else begin
            tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        CHECK: begin
          state_r <= NEXT;
        end
        NEXT: begin
          // t is the inner loop and s is the outer loop. Both wrap.
          t_r     <= t_r + {{(W-1){1'b0}}, 1'b1};
          x_cnt_r <= {W{1'b0}};
          ic_r    <= 1'b0;
          if (t_r == {W{1'b1}}) begin
            s_r <= s_r + {{(W-1){1'b0}}, 1'b1};
          end
          if (last_vec_s) begin
            state_r <= DONE;
          end else begin
            state_r <= SEARCH;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (fail_count == {FW{1'b0}});
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (fail_now_s) begin
        if (fail_count != {FW{1'b1}}) begin
          fail_count <= fail_count + {{(FW-1){1'b0}}, 1'b1};
        end
        if (fail_count == {FW{1'b0}}) begin
          first_fail_s <= s_r;
          first_fail_t <= t_r;
          first_fail_x <= fail_x_s;
        end
      end
    end
  end

endmodule
